// File: rtl/dpram_fifo.sv
// First-word-fall-through single-clock FIFO on per-bit distributed dual-port RAM.
// Define DPRAM_FIFO_ERR_EN to build the sticky overflow/underflow flags.
module dpram_fifo #(
    parameter int WIDTH        = 33,
    parameter int DEPTH_LOG2   = 6,
    parameter int AFULL_THRESH = 56
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH  = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] AF_LVL = (DEPTH_LOG2 + 1)'(AFULL_THRESH);

    logic [DEPTH_LOG2:0]   ra;
    logic [DEPTH_LOG2:0]   wa;
    logic [DEPTH_LOG2-1:0] ra_idx;
    logic [DEPTH_LOG2-1:0] wa_idx;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  mem_we;

    assign ra_idx = ra[DEPTH_LOG2-1:0];
    assign wa_idx = wa[DEPTH_LOG2-1:0];

    // Flags and count depend only on the registered pointers.
    assign empty       = (ra == wa);
    assign full        = (ra_idx == wa_idx) && (ra[DEPTH_LOG2] != wa[DEPTH_LOG2]);
    assign count       = wa - ra;
    assign almost_full = (count >= AF_LVL);

    // Handshake: rd_en pops the head shown on dout and takes effect only when
    // !empty; wr_en pushes din and takes effect when !full, or when full and a
    // pop is accepted in the same cycle (the write reuses the vacated slot).
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);
    assign mem_we = wr_acc && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            ra <= '0;
            wa <= '0;
        end else begin
            if (rd_acc) ra <= ra + 1'b1;
            if (wr_acc) wa <= wa + 1'b1;
        end
    end

    // One DEPTH x 1 slice per data bit: synchronous write, asynchronous read.
    for (genvar b = 0; b < WIDTH; b++) begin : g_slice
        logic [DEPTH-1:0] slice;

        always_ff @(posedge clk) begin
            if (mem_we) slice[wa_idx] <= din[b];
        end

        assign dout[b] = slice[ra_idx];
    end

`ifdef DPRAM_FIFO_ERR_EN
    logic ovf_q;
    logic udf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wr_en && !wr_acc) ovf_q <= 1'b1;
            if (rd_en && empty)   udf_q <= 1'b1;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_dpram_fifo.sv
// Scoreboard bench for dpram_fifo: driver keeps an occupancy model and an
// expected-data queue; a negedge monitor compares dout, count and flags.
module tb_dpram_fifo;

    localparam int W     = 33;
    localparam int DL2   = 6;
    localparam int DEPTH = 64;
    localparam int AFT   = 56;
`ifdef DPRAM_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0]   din   = '0;
    logic           wr_en = 1'b0;
    logic           rd_en = 1'b0;
    logic [W-1:0]   dout;
    logic           empty;
    logic           full;
    logic           almost_full;
    logic [DL2:0]   count;
    logic           overflow;
    logic           underflow;

    dpram_fifo #(.WIDTH(W), .DEPTH_LOG2(DL2), .AFULL_THRESH(AFT)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .dout        (dout),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int  m_cnt       = 0;
    bit  m_ovf       = 1'b0;
    bit  m_udf       = 1'b0;
    int  exp_cnt_now = 0;
    bit  exp_rd      = 1'b0;
    bit  exp_ovf_now = 1'b0;
    bit  exp_udf_now = 1'b0;
    bit  mon_en      = 1'b0;
    int  checks      = 0;
    int  errors      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // driver: one clock cycle of stimulus; model state is updated at issue time
    task automatic step(input bit w, input bit r, input logic [W-1:0] d);
        bit ra_ok;
        bit wa_ok;
        rst   = 1'b0;
        wr_en = w;
        rd_en = r;
        din   = d;
        ra_ok = r && (m_cnt > 0);
        wa_ok = w && ((m_cnt < DEPTH) || ra_ok);
        exp_cnt_now = m_cnt;
        exp_rd      = ra_ok;
        exp_ovf_now = m_ovf;
        exp_udf_now = m_udf;
        if (wa_ok) exp_q.push_back(d);
        if (w && !wa_ok) m_ovf = 1'b1;
        if (r && m_cnt == 0) m_udf = 1'b1;
        m_cnt = m_cnt + int'(wa_ok) - int'(ra_ok);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit w);
        rst   = 1'b1;
        wr_en = w;
        rd_en = 1'b0;
        din   = 33'h1_2345_6789;
        exp_cnt_now = m_cnt;
        exp_rd      = 1'b0;
        exp_ovf_now = m_ovf;
        exp_udf_now = m_udf;
        @(posedge clk);
        exp_q.delete();
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        mon_en = 1'b1;
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
    endtask

    // monitor: compares the registered state seen mid-cycle against the model
    always @(negedge clk) begin
        if (mon_en) begin
            chk("count", 64'(count), 64'(exp_cnt_now));
            chk("empty", 64'(empty), 64'(exp_cnt_now == 0));
            chk("full", 64'(full), 64'(exp_cnt_now == DEPTH));
            chk("almost_full", 64'(almost_full), 64'(exp_cnt_now >= AFT));
            chk("overflow", 64'(overflow), 64'(ERR_EN && exp_ovf_now));
            chk("underflow", 64'(underflow), 64'(ERR_EN && exp_udf_now));
            if (exp_cnt_now > 0) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_nonempty", 64'(0), 64'(1));
                end else begin
                    chk("dout_head", 64'(dout), 64'(exp_q[0]));
                    if (exp_rd) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [63:0] rnd;

        // 1: five writes then five reads
        do_reset(1'b0);
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, W'(i));
        step(1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // 2: fill to 64, a dropped 65th write, drain
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, W'(i));
        step(1'b1, 1'b0, W'(33'h0_0000_03FF));
        step(1'b0, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // 3: full with simultaneous read and write for 10 cycles, then drain
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, W'(i));
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, W'(32'h100 + i));
        step(1'b0, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // 4: both on empty accepts only the write; read on empty is ignored
        step(1'b1, 1'b1, W'(32'h1AB));
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // 5: random traffic, write-biased first half then read-biased
        for (int i = 0; i < 200; i++) begin
            rnd = {$urandom, $urandom};
            if (i < 100)
                step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rnd[W-1:0]);
            else
                step($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, rnd[W-1:0]);
        end
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b1, '0);

        // 6: reset with 30 entries held and a write presented
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, W'(32'h200 + i));
        do_reset(1'b1);
        step(1'b0, 1'b0, '0);
        chk("post_reset_empty", 64'(empty), 64'(1));
        chk("post_reset_count", 64'(count), 64'(0));
        step(1'b1, 1'b0, W'(32'h0AA));
        chk("post_reset_dout", 64'(dout), 64'(32'h0AA));
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
